// File: rtl/conv3x3_seq.sv
// 3x3 "same"-padded convolution sequencer: one MAC time-multiplexed over nine taps,
// bias, optional ReLU and saturation, results handed downstream over valid/ready.
module conv3x3_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int ADDR_W     = 6,
    parameter int RELU       = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic signed [DATA_WIDTH-1:0] w0,
    input  logic signed [DATA_WIDTH-1:0] w1,
    input  logic signed [DATA_WIDTH-1:0] w2,
    input  logic signed [DATA_WIDTH-1:0] w3,
    input  logic signed [DATA_WIDTH-1:0] w4,
    input  logic signed [DATA_WIDTH-1:0] w5,
    input  logic signed [DATA_WIDTH-1:0] w6,
    input  logic signed [DATA_WIDTH-1:0] w7,
    input  logic signed [DATA_WIDTH-1:0] w8,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic                         mem_rd_en,
    output logic        [ADDR_W-1:0]     mem_addr,
    input  logic signed [DATA_WIDTH-1:0] mem_rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic        [ADDR_W-1:0]     out_addr
);

    localparam int ACC_W = 2*DATA_WIDTH + 4;

    typedef enum logic [2:0] {IDLE, TAP, ACC, FIN, OUT} state_t;

    state_t                   state;
    logic [3:0]               tap;
    logic [ADDR_W-1:0]        row, col;
    logic                     pad_q;
    logic signed [ACC_W-1:0]  acc;

    // {in_bounds, address} of tap k around pixel (r,c); out-of-bounds yields all zero
    function automatic logic [ADDR_W:0] tap_fetch(input logic [ADDR_W-1:0] r,
                                                  input logic [ADDR_W-1:0] c,
                                                  input logic [3:0] k);
        int rr, cc;
        rr = int'(r) + int'(k) / 3 - 1;
        cc = int'(c) + int'(k) % 3 - 1;
        if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
            return {1'b1, ADDR_W'(rr*IMG_W + cc)};
        return '0;
    endfunction

    logic signed [DATA_WIDTH-1:0]   wt [9];
    logic        [3:0]              widx;
    logic signed [DATA_WIDTH-1:0]   operand;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        bias_ext, sum, shr, smax, smin;
    logic signed [DATA_WIDTH-1:0]   res;
    logic                           last_pix;
    logic        [ADDR_W-1:0]       nrow, ncol;

    always_comb begin
        wt[0] = w0; wt[1] = w1; wt[2] = w2;
        wt[3] = w3; wt[4] = w4; wt[5] = w5;
        wt[6] = w6; wt[7] = w7; wt[8] = w8;
        // memory data arriving now belongs to the tap issued one cycle earlier
        widx    = (state == ACC) ? 4'd8 : tap - 4'd1;
        operand = pad_q ? '0 : mem_rd_data;
        prod    = operand * wt[widx];

        bias_ext = ACC_W'(bias);
        sum      = acc + (bias_ext <<< FRAC_BITS);
        shr      = sum >>> FRAC_BITS;
        if (RELU != 0 && shr < 0)
            shr = '0;
        smax = '0;
        smax[DATA_WIDTH-2:0] = '1;
        smin = '1;
        smin[DATA_WIDTH-2:0] = '0;
        if (shr > smax)
            res = smax[DATA_WIDTH-1:0];
        else if (shr < smin)
            res = smin[DATA_WIDTH-1:0];
        else
            res = shr[DATA_WIDTH-1:0];

        last_pix = (row == ADDR_W'(IMG_H-1)) && (col == ADDR_W'(IMG_W-1));
        if (col == ADDR_W'(IMG_W-1)) begin
            ncol = '0;
            nrow = row + 1'b1;
        end else begin
            ncol = col + 1'b1;
            nrow = row;
        end
    end

    // read strobe/address are registered one cycle ahead of the TAP cycle they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tap       <= '0;
            row       <= '0;
            col       <= '0;
            pad_q     <= 1'b0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        row                   <= '0;
                        col                   <= '0;
                        acc                   <= '0;
                        tap                   <= '0;
                        busy                  <= 1'b1;
                        {mem_rd_en, mem_addr} <= tap_fetch('0, '0, 4'd0);
                        state                 <= TAP;
                    end
                end
                TAP: begin
                    pad_q <= !mem_rd_en;
                    if (tap != 4'd0)
                        acc <= acc + ACC_W'(prod);
                    if (tap == 4'd8) begin
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                        state     <= ACC;
                    end else begin
                        tap                   <= tap + 4'd1;
                        {mem_rd_en, mem_addr} <= tap_fetch(row, col, tap + 4'd1);
                    end
                end
                ACC: begin
                    acc   <= acc + ACC_W'(prod);
                    state <= FIN;
                end
                FIN: begin
                    out_data  <= res;
                    out_addr  <= ADDR_W'(int'(row)*IMG_W + int'(col));
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        tap       <= '0;
                        if (last_pix) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            row                   <= nrow;
                            col                   <= ncol;
                            {mem_rd_en, mem_addr} <= tap_fetch(nrow, ncol, 4'd0);
                            state                 <= TAP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_seq.sv
// Scoreboard bench for conv3x3_seq: two instances (ReLU on/off) share stimulus,
// expected results are queued at frame start and popped on every output handshake.
module tb_conv3x3_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        out_ready;
    logic [15:0] wv [9];
    logic [15:0] bias;
    logic [15:0] img [64];

    logic        busy0, done0, rd_en0, ov0;
    logic [5:0]  addr0, oa0;
    logic [15:0] rdd0, od0;
    logic        busy1, done1, rd_en1, ov1;
    logic [5:0]  addr1, oa1;
    logic [15:0] rdd1, od1;

    int checks = 0;
    int errors = 0;
    int dcnt0  = 0;
    int dcnt1  = 0;
    int mode   = 0;

    typedef struct {
        logic [5:0]  a;
        logic [15:0] d;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    conv3x3_seq #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_W(8), .IMG_H(8), .ADDR_W(6), .RELU(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
        .w0(wv[0]), .w1(wv[1]), .w2(wv[2]), .w3(wv[3]), .w4(wv[4]),
        .w5(wv[5]), .w6(wv[6]), .w7(wv[7]), .w8(wv[8]), .bias(bias),
        .mem_rd_en(rd_en0), .mem_addr(addr0), .mem_rd_data(rdd0),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_addr(oa0)
    );

    conv3x3_seq #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_W(8), .IMG_H(8), .ADDR_W(6), .RELU(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
        .w0(wv[0]), .w1(wv[1]), .w2(wv[2]), .w3(wv[3]), .w4(wv[4]),
        .w5(wv[5]), .w6(wv[6]), .w7(wv[7]), .w8(wv[8]), .bias(bias),
        .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rd_data(rdd1),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_addr(oa1)
    );

    // synchronous-read feature memories; junk on the bus when not read so padding must mask it
    always @(posedge clk) begin
        rdd0 <= rd_en0 ? img[addr0] : 16'h5a5a;
        rdd1 <= rd_en1 ? img[addr1] : 16'h5a5a;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // hand-derived expected result per test mode
    function automatic logic [15:0] exp_val(input int m, input bit relu, input int r, input int c);
        int n, a;
        a = r*8 + c;
        case (m)
            0: begin
                n = (3 - int'(r == 0) - int'(r == 7)) * (3 - int'(c == 0) - int'(c == 7));
                return 16'(n * 256);
            end
            1: return 16'(a*16 + 3);
            2: return 16'(((c < 7) ? (a+1)*16 : 0) + ((r < 7) ? (a+8)*16 : 0));
            3: return relu ? 16'h0000 : 16'hff80;
            4: return 16'h0066;
            5: return relu ? 16'h0000 : 16'hff00;
            6: return 16'h7fff;
            7: return relu ? 16'h0000 : 16'h8000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic setup(input int m);
        mode = m;
        for (int k = 0; k < 9; k++) wv[k] = 16'h0000;
        bias = 16'h0000;
        for (int i = 0; i < 64; i++) img[i] = 16'h0100;
        case (m)
            0: for (int k = 0; k < 9; k++) wv[k] = 16'h0100;
            1: begin wv[4] = 16'h0100; for (int i = 0; i < 64; i++) img[i] = 16'(i*16 + 3); end
            2: begin wv[5] = 16'h0100; wv[7] = 16'h0100; for (int i = 0; i < 64; i++) img[i] = 16'(i*16); end
            3: begin wv[4] = 16'h0080; for (int i = 0; i < 64; i++) img[i] = 16'hff01; end
            4: bias = 16'h0066;
            5: bias = 16'hff00;
            6: begin for (int k = 0; k < 9; k++) wv[k] = 16'h7fff; for (int i = 0; i < 64; i++) img[i] = 16'h7fff; end
            7: begin for (int k = 0; k < 9; k++) wv[k] = 16'h8000; for (int i = 0; i < 64; i++) img[i] = 16'h7fff; end
            default: ;
        endcase
    endtask

    task automatic push_frame();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                q0.push_back('{a: 6'(r*8 + c), d: exp_val(mode, 1'b1, r, c)});
                q1.push_back('{a: 6'(r*8 + c), d: exp_val(mode, 1'b0, r, c)});
            end
    endtask

    // monitors: pop and compare on every handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov0 && out_ready) begin
            if (q0.size() == 0) chk("u0_unexpected_output", {26'd0, oa0}, 32'hffffffff);
            else begin
                e = q0.pop_front();
                chk("u0_out_addr", {26'd0, oa0}, {26'd0, e.a});
                chk("u0_out_data", {16'd0, od0}, {16'd0, e.d});
            end
        end
        if (rst_n && ov1 && out_ready) begin
            if (q1.size() == 0) chk("u1_unexpected_output", {26'd0, oa1}, 32'hffffffff);
            else begin
                e = q1.pop_front();
                chk("u1_out_addr", {26'd0, oa1}, {26'd0, e.a});
                chk("u1_out_data", {16'd0, od1}, {16'd0, e.d});
            end
        end
        if (done0) begin
            dcnt0++;
            chk("u0_busy_low_at_done", {31'd0, busy0}, 32'd0);
            chk("u0_all_outputs_seen", q0.size(), 32'd0);
        end
        if (done1) begin
            dcnt1++;
            chk("u1_all_outputs_seen", q1.size(), 32'd0);
        end
    end

    task automatic check_reset_outputs();
        chk("rst_busy",      {31'd0, busy0 | busy1}, 32'd0);
        chk("rst_done",      {31'd0, done0 | done1}, 32'd0);
        chk("rst_mem_rd_en", {31'd0, rd_en0 | rd_en1}, 32'd0);
        chk("rst_out_valid", {31'd0, ov0 | ov1}, 32'd0);
        chk("rst_mem_addr",  {20'd0, addr0, addr1}, 32'd0);
        chk("rst_out_data",  {od0, od1}, 32'd0);
        chk("rst_out_addr",  {20'd0, oa0, oa1}, 32'd0);
    endtask

    task automatic run_frame(input bit stall, input bit start_on_done);
        int cyc, d0, d1;
        bit stalled;
        logic [15:0] hd;
        logic [5:0]  ha;
        d0 = dcnt0;
        d1 = dcnt1;
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", {31'd0, busy0}, 32'd1);
        // pixel (0,0): only taps 4,5,7,8 are inside the image
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("p0_rd_en_tap%0d", k), {31'd0, rd_en0},
                {31'd0, (k/3 >= 1) && (k%3 >= 1)});
            chk($sformatf("p0_addr_tap%0d", k), {26'd0, addr0},
                ((k/3 >= 1) && (k%3 >= 1)) ? 32'((k/3-1)*8 + (k%3-1)) : 32'd0);
            @(posedge clk); #1;
        end
        chk("p0_valid_acc",  {31'd0, ov0}, 32'd0);
        @(posedge clk); #1;
        chk("p0_valid_fin",  {31'd0, ov0}, 32'd0);
        @(posedge clk); #1;
        chk("p0_valid_first", {31'd0, ov0}, 32'd1);
        cyc = 0;
        stalled = 1'b0;
        while (!done0 && cyc < 3000) begin
            if (stall && !stalled && ov0 && oa0 == 6'd3) begin
                hd = od0;
                ha = oa0;
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    cyc++;
                    chk("stall_valid", {31'd0, ov0}, 32'd1);
                    chk("stall_data",  {16'd0, od0}, {16'd0, hd});
                    chk("stall_addr",  {26'd0, oa0}, {26'd0, ha});
                    chk("stall_no_read", {31'd0, rd_en0 | rd_en1}, 32'd0);
                end
                out_ready = 1'b1;
                stalled = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("frame_done_in_time", {31'd0, cyc < 3000}, 32'd1);
        if (stall) chk("stall_happened", {31'd0, stalled}, 32'd1);
        if (start_on_done) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            chk("start_on_done_ignored", {31'd0, busy0 | rd_en0}, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses_u0", dcnt0 - d0, 32'd1);
        chk("done_pulses_u1", dcnt1 - d1, 32'd1);
    endtask

    task automatic wait_out(input logic [5:0] a);
        int cyc;
        cyc = 0;
        while (!(ov0 && oa0 == a) && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("wait_pixel_in_time", {31'd0, cyc < 1000}, 32'd1);
    endtask

    task automatic reset_test();
        int d0;
        d0 = dcnt0;
        setup(0);
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_out(6'd5);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_out(6'd9);
        repeat (4) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        q0.delete();
        q1.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("no_done_after_abort", dcnt0 - d0, 32'd0);
        run_frame(1'b0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        setup(0);
        #12;
        check_reset_outputs();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        setup(0); run_frame(1'b0, 1'b0);
        setup(0); run_frame(1'b1, 1'b0);
        setup(1); run_frame(1'b0, 1'b1);
        for (int m = 2; m < 8; m++) begin
            setup(m);
            run_frame(1'b0, 1'b0);
        end
        reset_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
